// File: rtl/beam_delay_sum_pkg.sv
// Shared constants, sample/sum/delay types and sample conversion helpers
// for the programmable-delay beam former.
package beam_delay_sum_pkg;

    localparam int unsigned NBEAMS    = 4;
    localparam int unsigned NCHAN     = 8;
    localparam int unsigned NSAMP     = 8;
    localparam int unsigned NBITS     = 5;
    localparam int unsigned MAX_DELAY = 63;

    localparam int unsigned DLY_BITS   = $clog2(MAX_DELAY + 1);
    localparam int unsigned SUM_BITS   = NBITS + $clog2(NCHAN);
    localparam int unsigned DEPTH      = (MAX_DELAY + NSAMP - 1) / NSAMP + 1;
    localparam int unsigned NTAB       = NBEAMS * NCHAN;
    localparam int unsigned TAB_BITS   = $clog2(NTAB);
    localparam int unsigned ADDR_BITS  = TAB_BITS + 1;
    localparam int unsigned SAMP_SHIFT = $clog2(NSAMP);
    localparam int unsigned WORD_BITS  = NSAMP * NBITS;

    typedef logic        [NBITS-1:0]    sample_t;
    typedef logic signed [NBITS-1:0]    ssample_t;
    typedef logic signed [SUM_BITS-1:0] beam_sum_t;
    typedef logic        [DLY_BITS-1:0] delay_t;
    typedef sample_t     [NSAMP-1:0]    chan_word_t;

    // Offset binary to two's complement: flipping the MSB subtracts the offset.
    function automatic ssample_t to_signed(input sample_t s);
        return ssample_t'({~s[NBITS-1], s[NBITS-2:0]});
    endfunction

    function automatic beam_sum_t to_sum(input sample_t s);
        ssample_t v;
        v = to_signed(s);
        return beam_sum_t'({{(SUM_BITS - NBITS){v[NBITS-1]}}, v});
    endfunction

endpackage

// File: rtl/beam_delay_sum_chan_sample_store.sv
// Per-channel sample history plus one registered delay tap per beam.
// store[0] is the newest word; samples inside a word stay in time order.
module beam_delay_sum_chan_sample_store
    import beam_delay_sum_pkg::*;
(
    input  logic                    clk_i,
    input  chan_word_t              word_i,
    input  delay_t     [NBEAMS-1:0] dly_i,
    output chan_word_t [NBEAMS-1:0] taps_o
);

    localparam int unsigned IDX_BITS  = $clog2(DEPTH);
    localparam int unsigned PAIR_BITS = $clog2(2 * NSAMP);

    chan_word_t [DEPTH-1:0]                           store;
    logic       [NBEAMS-1:0][2*NSAMP-1:0][NBITS-1:0] pair_c;
    chan_word_t [NBEAMS-1:0]                          tap_sel_c;

    // Not reset: contents before the store fills are masked downstream by valid.
    always_ff @(posedge clk_i) begin
        store  <= {store[DEPTH-2:0], word_i};
        taps_o <= tap_sel_c;
    end

    // A delay of q words + r samples straddles words q (newer) and q+1 (older).
    always_comb begin
        pair_c    = '0;
        tap_sel_c = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            logic [IDX_BITS-1:0]   idx;
            logic [PAIR_BITS-1:0]  rem;
            idx       = IDX_BITS'(dly_i[b][DLY_BITS-1:SAMP_SHIFT]);
            rem       = PAIR_BITS'(dly_i[b][SAMP_SHIFT-1:0]);
            pair_c[b] = {store[idx], store[idx + IDX_BITS'(1)]};
            for (int k = 0; k < NSAMP; k++) begin
                tap_sel_c[b][k] = pair_c[b][PAIR_BITS'(k + NSAMP) - rem];
            end
        end
    end

endmodule

// File: rtl/beam_delay_sum.sv
// Runtime-programmable delay-and-sum beam former: shadow/active delay tables,
// per-channel delay stores and per-beam coherent sums of NCHAN channels.
module beam_delay_sum
    import beam_delay_sum_pkg::*;
(
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NCHAN*NSAMP*NBITS-1:0]       data_i,
    input  logic [ADDR_BITS-1:0]               dly_addr_i,
    input  logic [DLY_BITS:0]                  dly_dat_i,
    input  logic                               dly_wr_i,
    input  logic                               update_i,
    output logic [NBEAMS*NSAMP*SUM_BITS-1:0]   beam_o,
    output logic                               valid_o,
    output logic                               update_done_o,
    output logic                               dly_err_o
);

    localparam int unsigned CNT_BITS = $clog2(DEPTH + 3);

    delay_t     [NTAB-1:0]   shadow;
    delay_t     [NTAB-1:0]   active;
    delay_t     [NBEAMS-1:0] chan_dly [NCHAN];
    chan_word_t [NBEAMS-1:0] taps     [NCHAN];
    logic       [CNT_BITS-1:0] fill_cnt;

    beam_sum_t [NBEAMS-1:0][NSAMP-1:0] sum_c;
    logic addr_ok_c;
    logic dat_ok_c;
    logic wr_ok_c;
    logic wr_bad_c;

    assign addr_ok_c = dly_addr_i < ADDR_BITS'(NTAB);
    assign dat_ok_c  = dly_dat_i <= (DLY_BITS + 1)'(MAX_DELAY);
    assign wr_ok_c   = dly_wr_i & addr_ok_c & dat_ok_c;
    assign wr_bad_c  = dly_wr_i & ~(addr_ok_c & dat_ok_c);

    // Update copies the pre-write shadow; a bad write in the same cycle keeps the error set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow        <= '0;
            active        <= '0;
            update_done_o <= 1'b0;
            dly_err_o     <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                shadow[dly_addr_i[TAB_BITS-1:0]] <= DLY_BITS'(dly_dat_i);
            end
            if (update_i) begin
                active <= shadow;
            end
            update_done_o <= update_i;
            if (wr_bad_c) begin
                dly_err_o <= 1'b1;
            end else if (update_i) begin
                dly_err_o <= 1'b0;
            end
        end
    end

    // valid rises once the store, tap and adder stages all hold post-reset data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_cnt <= '0;
            valid_o  <= 1'b0;
        end else if (!valid_o) begin
            fill_cnt <= fill_cnt + CNT_BITS'(1);
            valid_o  <= (fill_cnt == CNT_BITS'(DEPTH + 2));
        end
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        for (genvar b = 0; b < NBEAMS; b++) begin : g_dly
            assign chan_dly[c][b] = active[b*NCHAN + c];
        end

        beam_delay_sum_chan_sample_store u_store (
            .clk_i  (clk_i),
            .word_i (chan_word_t'(data_i[c*WORD_BITS +: WORD_BITS])),
            .dly_i  (chan_dly[c]),
            .taps_o (taps[c])
        );
    end

    always_comb begin
        sum_c = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            for (int k = 0; k < NSAMP; k++) begin
                beam_sum_t acc;
                acc = '0;
                for (int c = 0; c < NCHAN; c++) begin
                    acc = acc + to_sum(taps[c][b][k]);
                end
                sum_c[b][k] = acc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beam_o <= '0;
        end else begin
            beam_o <= sum_c;
        end
    end

endmodule

// File: tb/tb_beam_delay_sum.sv
// Randomised and directed bench for beam_delay_sum against a sample-history
// reference model of the delay-and-sum rule.
module tb_beam_delay_sum;
    import beam_delay_sum_pkg::*;

    localparam int unsigned BW   = NBEAMS * NSAMP * SUM_BITS;
    localparam int unsigned DW   = NCHAN * NSAMP * NBITS;
    localparam int          MAXC = 1500;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic [DW-1:0]         data_i = '0;
    logic [ADDR_BITS-1:0]  dly_addr_i = '0;
    logic [DLY_BITS:0]     dly_dat_i = '0;
    logic                  dly_wr_i = 1'b0;
    logic                  update_i = 1'b0;
    logic [BW-1:0]         beam_o;
    logic                  valid_o;
    logic                  update_done_o;
    logic                  dly_err_o;

    int checks = 0;
    int errors = 0;

    int samp     [NCHAN][MAXC*NSAMP];
    int act_hist [MAXC][NTAB];
    int sh [NTAB];
    int ac [NTAB];
    int exp_err   = 0;
    int exp_done  = 0;
    int since_rst = 0;
    int n         = 0;

    beam_delay_sum dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_i        (data_i),
        .dly_addr_i    (dly_addr_i),
        .dly_dat_i     (dly_dat_i),
        .dly_wr_i      (dly_wr_i),
        .update_i      (update_i),
        .beam_o        (beam_o),
        .valid_o       (valid_o),
        .update_done_o (update_done_o),
        .dly_err_o     (dly_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [SUM_BITS-1:0] field(input logic [BW-1:0] v, input int b, input int k);
        return v[(b*NSAMP + k)*SUM_BITS +: SUM_BITS];
    endfunction

    task automatic set_all(input int v);
        for (int i = 0; i < NCHAN*NSAMP; i++) data_i[i*NBITS +: NBITS] = NBITS'(v);
    endtask

    task automatic set_samp(input int c, input int s, input int v);
        data_i[(c*NSAMP + s)*NBITS +: NBITS] = NBITS'(v);
    endtask

    task automatic set_rand();
        for (int i = 0; i < NCHAN*NSAMP; i++) data_i[i*NBITS +: NBITS] = NBITS'($urandom_range(0, 31));
    endtask

    // One clock: update the reference model from the sampled inputs, then check all outputs.
    task automatic tick();
        logic [BW-1:0] want;
        int r, wr, upd, addr, dat, bad, ev, t, acc;
        @(posedge clk_i);
        if (n >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", n, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        r    = int'(rst_i);
        wr   = int'(dly_wr_i);
        upd  = int'(update_i);
        addr = int'(dly_addr_i);
        dat  = int'(dly_dat_i);
        for (int c = 0; c < NCHAN; c++)
            for (int s = 0; s < NSAMP; s++)
                samp[c][n*NSAMP + s] = int'(data_i[(c*NSAMP + s)*NBITS +: NBITS]) - (1 << (NBITS-1));
        if (r != 0) begin
            sh = '{default: 0};
            ac = '{default: 0};
            exp_err = 0;
            exp_done = 0;
            since_rst = 0;
        end else begin
            bad = (wr != 0 && (addr >= int'(NTAB) || dat > int'(MAX_DELAY))) ? 1 : 0;
            exp_done = upd;
            if (upd != 0) ac = sh;
            if (wr != 0 && bad == 0) sh[addr] = dat;
            if (bad != 0) exp_err = 1;
            else if (upd != 0) exp_err = 0;
            since_rst++;
        end
        act_hist[n] = ac;
        ev = (since_rst >= int'(DEPTH) + 3) ? 1 : 0;
        #1;
        check($sformatf("valid@%0d", n), BW'(valid_o), BW'(ev));
        check($sformatf("update_done@%0d", n), BW'(update_done_o), BW'(exp_done));
        check($sformatf("dly_err@%0d", n), BW'(dly_err_o), BW'(exp_err));
        if (r != 0) begin
            check($sformatf("beam_rst@%0d", n), beam_o, '0);
        end else if (ev != 0) begin
            t = n - 2;
            want = '0;
            for (int b = 0; b < NBEAMS; b++)
                for (int k = 0; k < NSAMP; k++) begin
                    acc = 0;
                    for (int c = 0; c < NCHAN; c++)
                        acc += samp[c][t*NSAMP + k - act_hist[t][b*NCHAN + c]];
                    want[(b*NSAMP + k)*SUM_BITS +: SUM_BITS] = SUM_BITS'(acc);
                end
            check($sformatf("beam@%0d", n), beam_o, want);
        end
        n++;
    endtask

    task automatic write(input int addr, input int dat);
        dly_wr_i   = 1'b1;
        dly_addr_i = ADDR_BITS'(addr);
        dly_dat_i  = (DLY_BITS + 1)'(dat);
    endtask

    task automatic pulse_ch(input int c, input int s);
        set_samp(c, s, 31);
        tick();
        set_all(16);
        tick();
        tick();
    endtask

    initial begin
        logic [BW-1:0] want;

        // Reset and fill with neutral samples.
        set_all(16);
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (14) tick();

        // Single hot sample, all delays zero.
        pulse_ch(0, 3);
        want = '0;
        for (int b = 0; b < NBEAMS; b++) want[(b*NSAMP + 3)*SUM_BITS +: SUM_BITS] = SUM_BITS'(15);
        check("t1_impulse", beam_o, want);

        // beam1 ch2 delayed by 11 samples.
        write(1*NCHAN + 2, 11);
        tick();
        dly_wr_i = 1'b0;
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        check("t2_update_done", BW'(update_done_o), BW'(1));
        repeat (3) tick();
        pulse_ch(2, 0);
        check("t2_beam0_s0", BW'(field(beam_o, 0, 0)), BW'(15));
        tick();
        check("t2_beam1_s3", BW'(field(beam_o, 1, 3)), BW'(15));

        // Full-scale sums.
        set_all(31);
        repeat (14) tick();
        for (int i = 0; i < NBEAMS*NSAMP; i++) want[i*SUM_BITS +: SUM_BITS] = SUM_BITS'(120);
        check("t3_max", beam_o, want);
        set_all(0);
        repeat (14) tick();
        for (int i = 0; i < NBEAMS*NSAMP; i++) want[i*SUM_BITS +: SUM_BITS] = SUM_BITS'(-128);
        check("t3_min", beam_o, want);

        // Rejected writes.
        set_rand();
        write(32, 5);
        tick();
        dly_wr_i = 1'b0;
        check("t4_err_addr", BW'(dly_err_o), BW'(1));
        write(3, 64);
        tick();
        dly_wr_i = 1'b0;
        check("t4_err_dat", BW'(dly_err_o), BW'(1));
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        check("t4_err_clear", BW'(dly_err_o), BW'(0));

        // Write coinciding with update only reaches the shadow table.
        set_all(16);
        write(0, 5);
        update_i = 1'b1;
        tick();
        dly_wr_i = 1'b0;
        update_i = 1'b0;
        repeat (10) tick();
        pulse_ch(0, 0);
        check("t5_old_delay", BW'(field(beam_o, 0, 0)), BW'(15));
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        repeat (10) tick();
        pulse_ch(0, 0);
        check("t5_new_delay", BW'(field(beam_o, 0, 5)), BW'(15));
        write(40, 1);
        update_i = 1'b1;
        tick();
        dly_wr_i = 1'b0;
        update_i = 1'b0;
        check("t5_err_set_wins", BW'(dly_err_o), BW'(1));

        // Random traffic with random table writes and updates.
        for (int i = 0; i < 300; i++) begin
            set_rand();
            dly_wr_i = ($urandom_range(0, 3) == 0);
            dly_addr_i = ADDR_BITS'($urandom_range(0, 35));
            dly_dat_i = (DLY_BITS + 1)'($urandom_range(0, 70));
            update_i = ($urandom_range(0, 11) == 0);
            tick();
        end
        dly_wr_i = 1'b0;
        update_i = 1'b0;

        // Mid-stream reset zeroes tables and restarts the fill.
        rst_i = 1'b1;
        tick();
        check("t6_valid_drop", BW'(valid_o), BW'(0));
        check("t6_beam_zero", beam_o, '0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            set_rand();
            tick();
        end

        // Update while the output is still filling.
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        set_rand();
        tick();
        write(9, 20);
        tick();
        dly_wr_i = 1'b0;
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        check("t6_update_while_filling", BW'(update_done_o), BW'(1));
        for (int i = 0; i < 40; i++) begin
            set_rand();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
